// File: rtl/rtc_wr_seq.sv
// rtc_wr_seq: walks a range of data channels and writes each one to the RTC
// as a four-phase bus cycle (address low/high, data low/high). Each phase
// lasts TPH clocks.
module rtc_wr_seq #(
  parameter int         TPH       = 4,
  parameter logic [7:0] ADDR_BASE = 8'h21,
  parameter int         NCH       = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] first,
  input  logic [3:0] last,
  output logic [3:0] sel,
  output logic       r_s,
  output logic [7:0] addr,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, A_LO, A_HI, D_LO, D_HI, NEXT, FIN} state_t;

  localparam logic [7:0] PH_LOAD = 8'(TPH - 1);

  state_t     state, state_nxt;
  logic [3:0] idx, last_q;
  logic [7:0] pcnt;
  logic       err_q;
  logic       accept, range_ok, ph_end;

  assign accept   = (state == IDLE) && start;
  assign range_ok = (first <= last) && ({28'd0, last} < 32'(NCH));
  assign ph_end   = (pcnt == 8'd0);

  assign sel  = idx;
  assign addr = ADDR_BASE + {4'd0, idx};
  assign rd_n = 1'b1;
  assign err  = err_q;

  // State, phase counter, channel index and captured range.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= 4'd0;
      last_q <= 4'd0;
      pcnt   <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter reloads on every state change so each phase gets TPH clocks.
      if (state_nxt != state)  pcnt <= PH_LOAD;
      else if (pcnt != 8'd0)   pcnt <= pcnt - 8'd1;
      if (accept) begin
        err_q  <= !range_ok;
        last_q <= last;
        if (range_ok) idx <= first;
      end
      if (state == NEXT && idx != last_q) idx <= idx + 4'd1;
    end
  end

  // Next-state logic and per-state strobe decode.
  always_comb begin
    state_nxt = state;
    cs_n      = 1'b1;
    wr_n      = 1'b1;
    a_d       = 1'b0;
    r_s       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = range_ok ? A_LO : FIN;
      A_LO: begin
        cs_n = 1'b0;
        wr_n = 1'b0;
        busy = 1'b1;
        if (ph_end) state_nxt = A_HI;
      end
      A_HI: begin
        busy = 1'b1;
        if (ph_end) state_nxt = D_LO;
      end
      D_LO: begin
        cs_n = 1'b0;
        wr_n = 1'b0;
        a_d  = 1'b1;
        r_s  = 1'b1;
        busy = 1'b1;
        if (ph_end) state_nxt = D_HI;
      end
      D_HI: begin
        a_d  = 1'b1;
        r_s  = 1'b1;
        busy = 1'b1;
        if (ph_end) state_nxt = NEXT;
      end
      NEXT: begin
        busy      = 1'b1;
        state_nxt = (idx == last_q) ? FIN : A_LO;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rtc_wr_seq.sv
// Bench for rtc_wr_seq: a negedge monitor records bus transfers, phase run
// lengths and done pulses; each test pushes expected records and compares.
module tb_rtc_wr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // TPH=4 instance
  logic       reset = 1'b0, start = 1'b0;
  logic [3:0] first = 4'd0, last = 4'd0;
  logic [3:0] sel;
  logic [7:0] addr;
  logic       r_s, a_d, cs_n, wr_n, rd_n, busy, done, err;
  // TPH=1 instance
  logic       reset1 = 1'b0, start1 = 1'b0;
  logic [3:0] first1 = 4'd0, last1 = 4'd0;
  logic [3:0] sel1;
  logic [7:0] addr1;
  logic       r_s1, a_d1, cs_n1, wr_n1, rd_n1, busy1, done1, err1;

  rtc_wr_seq #(.TPH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .first(first), .last(last),
    .sel(sel), .r_s(r_s), .addr(addr), .a_d(a_d), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .busy(busy), .done(done), .err(err));

  rtc_wr_seq #(.TPH(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .first(first1), .last(last1),
    .sel(sel1), .r_s(r_s1), .addr(addr1), .a_d(a_d1), .cs_n(cs_n1), .wr_n(wr_n1),
    .rd_n(rd_n1), .busy(busy1), .done(done1), .err(err1));

  // Monitor source select
  logic       mon1 = 1'b0;
  logic [3:0] m_sel;
  logic [7:0] m_addr;
  logic       m_r_s, m_a_d, m_cs_n, m_wr_n, m_rd_n, m_busy, m_done, m_err;
  assign m_sel  = mon1 ? sel1  : sel;
  assign m_addr = mon1 ? addr1 : addr;
  assign m_r_s  = mon1 ? r_s1  : r_s;
  assign m_a_d  = mon1 ? a_d1  : a_d;
  assign m_cs_n = mon1 ? cs_n1 : cs_n;
  assign m_wr_n = mon1 ? wr_n1 : wr_n;
  assign m_rd_n = mon1 ? rd_n1 : rd_n;
  assign m_busy = mon1 ? busy1 : busy;
  assign m_done = mon1 ? done1 : done;
  assign m_err  = mon1 ? err1  : err;

  typedef struct {int lat; logic err;} done_t;

  done_t       obs_d[$];
  logic [12:0] obs_x[$], exp_x[$];
  int          obs_run[$], exp_run[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0;
  int wr_falls = 0, strobe_bad = 0, sel_bad = 0, cs_low = 0, run = 0;
  logic [2:0] key, pkey = 3'b010;
  logic       pwr = 1'b1, pbusy = 1'b0;
  logic [3:0] psel = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation recorder
  always @(negedge clk) begin
    key = {m_busy, m_cs_n, m_a_d};
    if (m_busy && pbusy && m_sel != psel && !(key == 3'b100 && pkey == 3'b110)) sel_bad++;
    if (key != pkey) begin
      if (pkey[2]) obs_run.push_back(run);
      run = 1;
    end else run++;
    pkey = key;
    if (pwr && !m_wr_n) begin
      obs_x.push_back({m_a_d, m_sel, m_addr});
      wr_falls++;
    end
    pwr = m_wr_n;
    if (!m_cs_n) cs_low++;
    if (m_done) obs_d.push_back('{cyc - acc_cyc, m_err});
    if (!m_rd_n || (m_r_s != m_a_d) || (m_cs_n != m_wr_n) ||
        (!m_busy && !m_cs_n) || (m_done && m_busy)) strobe_bad++;
    pbusy = m_busy;
    psel  = m_sel;
  end

  task automatic clear_obs();
    obs_d.delete(); obs_x.delete(); exp_x.delete(); obs_run.delete(); exp_run.delete();
    wr_falls = 0; strobe_bad = 0; sel_bad = 0; cs_low = 0;
  endtask

  // Scoreboard fill: two bus writes and five runs per channel.
  task automatic push_exp(input int f, input int l, input int tph);
    for (int i = f; i <= l; i++) begin
      exp_x.push_back({1'b0, 4'(i), 8'(8'h21 + i)});
      exp_x.push_back({1'b1, 4'(i), 8'(8'h21 + i)});
      repeat (4) exp_run.push_back(tph);
      exp_run.push_back(1);
    end
  endtask

  task automatic pulse(input bit which, input logic [3:0] f, input logic [3:0] l);
    @(posedge clk); #1;
    if (which) begin first1 = f; last1 = l; start1 = 1'b1; end
    else       begin first  = f; last  = l; start  = 1'b1; end
    acc_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (obs_d.size() == 0 && k < bound) begin @(posedge clk); k++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset1 = 1'b0; start = 1'b1; start1 = 1'b1; first = 4'd5; last = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sel, r_s, a_d, cs_n, wr_n, rd_n, busy, done, err, addr} !== {4'd0, 8'b0_0111000, 8'h21}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h",
               {sel, r_s, a_d, cs_n, wr_n, rd_n, busy, done, err, addr}, {4'd0, 8'b0_0111000, 8'h21});
    end
    n_cmp++;
    if ({sel1, r_s1, a_d1, cs_n1, wr_n1, rd_n1, busy1, done1, err1, addr1} !== {4'd0, 8'b0_0111000, 8'h21}) begin
      n_bad++;
      $display("FAIL reset_outputs_tph1: got %h want %h",
               {sel1, r_s1, a_d1, cs_n1, wr_n1, rd_n1, busy1, done1, err1, addr1}, {4'd0, 8'b0_0111000, 8'h21});
    end
    start = 1'b0; start1 = 1'b0; reset = 1'b1; reset1 = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    done_t d; logic [12:0] e, o; int er, orr;
    mon1 = 1'b0; clear_obs(); push_exp(5, 5, 4);
    pulse(1'b0, 4'd5, 4'd5);
    wait_done(100);
    n_cmp++;
    if (obs_d.size() == 0) begin n_bad++; $display("FAIL single_done: no done pulse, want latency 18"); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 18 || d.err !== 1'b0) begin
        n_bad++; $display("FAIL single_done: lat %0d err %b want 18 0", d.lat, d.err);
      end
    end
    n_cmp++;
    if (obs_x.size() != exp_x.size()) begin
      n_bad++; $display("FAIL single_xfer_count: got %0d want %0d", obs_x.size(), exp_x.size());
    end
    while (exp_x.size() > 0 && obs_x.size() > 0) begin
      e = exp_x.pop_front(); o = obs_x.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_xfer: got %h want %h", o, e); end
    end
    while (exp_run.size() > 0) begin
      er = exp_run.pop_front(); orr = (obs_run.size() > 0) ? obs_run.pop_front() : -1; n_cmp++;
      if (orr !== er) begin n_bad++; $display("FAIL single_phase_len: got %0d want %0d", orr, er); end
    end
    n_cmp++;
    if (strobe_bad !== 0 || sel_bad !== 0 || cs_low !== 8) begin
      n_bad++; $display("FAIL single_strobes: bad %0d selbad %0d cs_low %0d want 0 0 8", strobe_bad, sel_bad, cs_low);
    end
  endtask

  task automatic test_sweep();
    done_t d; logic [12:0] e, o;
    mon1 = 1'b0; clear_obs(); push_exp(0, 13, 4);
    pulse(1'b0, 4'd0, 4'd13);
    wait_done(400);
    n_cmp++;
    if (obs_d.size() == 0) begin n_bad++; $display("FAIL sweep_done: no done pulse, want latency 239"); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 239 || d.err !== 1'b0) begin
        n_bad++; $display("FAIL sweep_done: lat %0d err %b want 239 0", d.lat, d.err);
      end
    end
    n_cmp++;
    if (wr_falls !== 28) begin n_bad++; $display("FAIL sweep_wr_pulses: got %0d want 28", wr_falls); end
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); o = (obs_x.size() > 0) ? obs_x.pop_front() : 13'h1fff; n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sweep_xfer: got %h want %h", o, e); end
    end
    n_cmp++;
    if (strobe_bad !== 0 || sel_bad !== 0) begin
      n_bad++; $display("FAIL sweep_strobes: bad %0d selbad %0d want 0 0", strobe_bad, sel_bad);
    end
  endtask

  task automatic test_bad_range();
    done_t d;
    mon1 = 1'b0; clear_obs();
    @(posedge clk); #1;
    first = 4'd7; last = 4'd3; start = 1'b1; acc_cyc = cyc;
    @(posedge clk); #1;
    // Valid request presented during the FIN cycle must be dropped.
    first = 4'd0; last = 4'd0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_bad++; $display("FAIL bad_fin_cycle: done %b err %b want 1 1", done, err);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_d.size() != 1) begin n_bad++; $display("FAIL bad_done_count: got %0d want 1", obs_d.size()); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 1 || d.err !== 1'b1) begin
        n_bad++; $display("FAIL bad_done: lat %0d err %b want 1 1", d.lat, d.err);
      end
    end
    n_cmp++;
    if (cs_low !== 0 || wr_falls !== 0 || obs_x.size() != 0) begin
      n_bad++; $display("FAIL bad_strobes: cs_low %0d wr_falls %0d want 0 0", cs_low, wr_falls);
    end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err_hold: got %b want 1", err); end

    clear_obs();
    pulse(1'b0, 4'd0, 4'd14);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_d.size() != 1) begin n_bad++; $display("FAIL bad14_done_count: got %0d want 1", obs_d.size()); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 1 || d.err !== 1'b1) begin
        n_bad++; $display("FAIL bad14_done: lat %0d err %b want 1 1", d.lat, d.err);
      end
    end
    n_cmp++;
    if (cs_low !== 0 || wr_falls !== 0) begin
      n_bad++; $display("FAIL bad14_strobes: cs_low %0d wr_falls %0d want 0 0", cs_low, wr_falls);
    end
  endtask

  task automatic test_busy_start();
    done_t d; logic [12:0] e, o;
    mon1 = 1'b0; clear_obs(); push_exp(2, 4, 4);
    pulse(1'b0, 4'd2, 4'd4);
    while (cyc < acc_cyc + 10) begin @(posedge clk); #1; end
    n_cmp++;
    if (a_d !== 1'b1 || cs_n !== 1'b0 || sel !== 4'd2) begin
      n_bad++; $display("FAIL busy_in_dlo: a_d %b cs_n %b sel %0d want 1 0 2", a_d, cs_n, sel);
    end
    first = 4'd0; last = 4'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    n_cmp++;
    if (obs_d.size() == 0) begin n_bad++; $display("FAIL busy_done: no done pulse, want latency 52"); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 52 || d.err !== 1'b0) begin
        n_bad++; $display("FAIL busy_done: lat %0d err %b want 52 0", d.lat, d.err);
      end
    end
    n_cmp++;
    if (obs_x.size() != exp_x.size()) begin
      n_bad++; $display("FAIL busy_xfer_count: got %0d want %0d", obs_x.size(), exp_x.size());
    end
    while (exp_x.size() > 0 && obs_x.size() > 0) begin
      e = exp_x.pop_front(); o = obs_x.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL busy_xfer: got %h want %h", o, e); end
    end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_d.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_extra_run: done %0d busy %b want 0 0", obs_d.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    done_t d; logic [12:0] e, o;
    mon1 = 1'b0; clear_obs();
    pulse(1'b0, 4'd6, 4'd8);
    n_cmp++;
    if (cs_n !== 1'b0 || a_d !== 1'b0 || sel !== 4'd6) begin
      n_bad++; $display("FAIL rmid_alo: cs_n %b a_d %b sel %0d want 0 0 6", cs_n, a_d, sel);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({cs_n, wr_n, busy, sel, done, addr} !== {3'b110, 4'd0, 1'b0, 8'h21}) begin
      n_bad++; $display("FAIL rmid_abort: got %h want %h", {cs_n, wr_n, busy, sel, done, addr},
                        {3'b110, 4'd0, 1'b0, 8'h21});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_d.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rmid_no_done: done %0d busy %b want 0 0", obs_d.size(), busy);
    end
    // Start presented with release: must be taken on the first IDLE cycle.
    clear_obs(); push_exp(1, 1, 4);
    reset = 1'b1; first = 4'd1; last = 4'd1; start = 1'b1; acc_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    n_cmp++;
    if (obs_d.size() == 0) begin n_bad++; $display("FAIL rmid_restart: no done pulse, want latency 18"); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 18 || d.err !== 1'b0) begin
        n_bad++; $display("FAIL rmid_restart: lat %0d err %b want 18 0", d.lat, d.err);
      end
    end
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); o = (obs_x.size() > 0) ? obs_x.pop_front() : 13'h1fff; n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rmid_xfer: got %h want %h", o, e); end
    end
  endtask

  task automatic test_tph1();
    done_t d; logic [12:0] e, o; int er, orr;
    mon1 = 1'b1;
    repeat (2) @(posedge clk);
    clear_obs(); push_exp(12, 13, 1);
    pulse(1'b1, 4'd12, 4'd13);
    wait_done(50);
    n_cmp++;
    if (obs_d.size() == 0) begin n_bad++; $display("FAIL tph1_done: no done pulse, want latency 11"); end
    else begin
      d = obs_d.pop_front();
      if (d.lat !== 11 || d.err !== 1'b0) begin
        n_bad++; $display("FAIL tph1_done: lat %0d err %b want 11 0", d.lat, d.err);
      end
    end
    while (exp_run.size() > 0) begin
      er = exp_run.pop_front(); orr = (obs_run.size() > 0) ? obs_run.pop_front() : -1; n_cmp++;
      if (orr !== er) begin n_bad++; $display("FAIL tph1_phase_len: got %0d want %0d", orr, er); end
    end
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); o = (obs_x.size() > 0) ? obs_x.pop_front() : 13'h1fff; n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL tph1_xfer: got %h want %h", o, e); end
    end
    n_cmp++;
    if (strobe_bad !== 0 || sel_bad !== 0) begin
      n_bad++; $display("FAIL tph1_strobes: bad %0d selbad %0d want 0 0", strobe_bad, sel_bad);
    end
    mon1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_bad_range();
    test_busy_start();
    test_reset_mid();
    test_tph1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
